// File: rtl/addsub_result_buf_pkg.sv
// Shared definitions for the add/subtract datapath and its result buffer.
// Entry layout, MSB to LSB: {S, cout, ov_flag, zero, neg}.
package addsub_result_buf_pkg;

    localparam int DATA_W = 8;

    localparam int ENT_N  = 0;
    localparam int ENT_Z  = 1;
    localparam int ENT_OV = 2;
    localparam int ENT_C  = 3;
    localparam int ENT_S  = 4;
    localparam int ENT_W  = ENT_S + DATA_W;

    // Zero/negative status is computed once at push time and stored with the entry.
    function automatic logic [ENT_W-1:0] pack_entry(input logic [DATA_W-1:0] s,
                                                    input logic              c,
                                                    input logic              ov);
        return {s, c, ov, (s == '0), s[DATA_W-1]};
    endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// Register-array storage for the result FIFO: one write port, asynchronous read.
// The array has no reset; validity is tracked by the pointers in the parent.
module result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 12,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/addsub_result_buf.sv
// Result buffer behind the 8-bit add/subtract unit: DEPTH-entry FIFO with
// per-entry zero/negative status and a sticky overflow flag.
module addsub_result_buf
    import addsub_result_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] S,
    input  logic              cout,
    input  logic              ov_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_cout,
    output logic              out_ov,
    output logic              out_zero,
    output logic              out_neg,
    output logic [CW-1:0]     count,
    output logic              sticky_ov,
    input  logic              clr_sticky
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [ENT_W-1:0] rdata;
    logic             push;
    logic             pop;

    // Handshake outputs depend only on the registered count.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            sticky_ov <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A set in the same cycle as a clear takes priority.
            sticky_ov <= (sticky_ov & ~clr_sticky) | (push & ov_flag);
        end
    end

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (pack_entry(S, cout, ov_flag)),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign out_data = rdata[ENT_S +: DATA_W];
    assign out_cout = rdata[ENT_C];
    assign out_ov   = rdata[ENT_OV];
    assign out_zero = rdata[ENT_Z];
    assign out_neg  = rdata[ENT_N];

endmodule

// File: tb/tb_addsub_result_buf.sv
// Self-checking bench for addsub_result_buf: directed and random traffic
// compared against a queue-based model of the buffer.
module tb_addsub_result_buf;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] S;
    logic       cout;
    logic       ov_flag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_cout;
    logic       out_ov;
    logic       out_zero;
    logic       out_neg;
    logic [2:0] count;
    logic       sticky_ov;
    logic       clr_sticky;

    logic [9:0] q[$];
    bit         m_sticky;
    int         checks = 0;
    int         errors = 0;

    addsub_result_buf #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .S          (S),
        .cout       (cout),
        .ov_flag    (ov_flag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cout   (out_cout),
        .out_ov     (out_ov),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count),
        .sticky_ov  (sticky_ov),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] s, input logic c, input logic ov,
                         input logic iv, input logic ordy, input logic clr);
        S = s; cout = c; ov_flag = ov; in_valid = iv; out_ready = ordy; clr_sticky = clr;
    endtask

    // One clock: model decides push/pop from its own occupancy, then advances.
    task automatic tick();
        bit         p_push;
        bit         p_pop;
        logic [9:0] ent;
        p_push = in_valid && (q.size() < DEPTH);
        p_pop  = out_ready && (q.size() > 0);
        ent    = {S, cout, ov_flag};
        @(posedge clk);
        if (p_pop)  void'(q.pop_front());
        if (p_push) q.push_back(ent);
        m_sticky = (m_sticky && !clr_sticky) || (p_push && ov_flag);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [9:0] h;
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".in_ready"}, in_ready, q.size() < DEPTH);
        chk({tag, ".out_valid"}, out_valid, q.size() > 0);
        chk({tag, ".sticky"}, sticky_ov, m_sticky);
        if (q.size() > 0) begin
            h = q[0];
            chk({tag, ".data"}, out_data, h[9:2]);
            chk({tag, ".cout"}, out_cout, h[1]);
            chk({tag, ".ov"}, out_ov, h[0]);
            chk({tag, ".zero"}, out_zero, h[9:2] == 8'h00);
            chk({tag, ".neg"}, out_neg, h[9]);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset.count", count, 0);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.sticky", sticky_ov, 0);
        #10 rst = 1'b0;

        // Fill to full, fifth value must be dropped.
        for (int i = 1; i <= 5; i++) begin
            drive(8'(i), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            check_all("fill");
        end
        chk("full.count", count, 4);
        chk("full.in_ready", in_ready, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain.order", out_data, i);
            tick();
            check_all("drain");
        end
        chk("drain.empty", out_valid, 0);

        // Status flags.
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("flag.zero", out_zero, 1);
        chk("flag.zero_neg", out_neg, 0);
        drive(8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        chk("flag.neg", out_neg, 1);
        chk("flag.ov", out_ov, 1);
        chk("flag.cout", out_cout, 1);
        chk("flag.sticky_set", sticky_ov, 1);
        check_all("flag");

        // Sticky clear, then set-wins-over-clear.
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("sticky.clr", sticky_ov, 0);
        drive(8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("sticky.set_wins", sticky_ov, 1);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_all("sticky");

        // Streaming: push and pop every cycle, occupancy settles at 1.
        for (int i = 0; i < 20; i++) begin
            drive(8'(8'h30 + i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("stream.count", count, 1);
            chk("stream.data", out_data, 8'h30 + i);
            check_all("stream");
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset mid-operation with three entries and sticky set.
        for (int i = 0; i < 3; i++) begin
            drive(8'(8'h50 + i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check_all("pre_rst");
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst.count", count, 0);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.sticky", sticky_ov, 0);
        q.delete();
        m_sticky = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        drive(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("postrst.first", out_data, 8'hAA);
        check_all("postrst");
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Wrap-around: bursts of 3 pushes then 3 pops.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 3; i++) begin
                drive(8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
                tick();
                chk("wrap.bound", count <= 4, 1);
                check_all("wrap_push");
            end
            for (int i = 0; i < 3; i++) begin
                drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                tick();
                check_all("wrap_pop");
            end
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(8'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
            tick();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
